// File: rtl/caminho_dados_xyz_pkg.sv
// Shared definitions for the X/Y/Z datapath: program-memory opcodes and the
// operation select used by the ULA.
package caminho_dados_xyz_pkg;

    localparam logic [3:0] OP_LOAD_X  = 4'b0000;
    localparam logic [3:0] OP_LOAD_Y  = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SHR_Y   = 4'b0011;
    localparam logic [3:0] OP_STORE_Z = 4'b0100;
    localparam logic [3:0] OP_SUB     = 4'b0101;

    typedef enum logic [1:0] {
        ULA_ADD = 2'd0,
        ULA_SUB = 2'd1,
        ULA_SHR = 2'd2
    } ula_op_t;

endpackage

// File: rtl/caminho_dados_xyz_ula.sv
// Combinational ULA: unsigned wrapping add, subtract with borrow, and logical
// shift-right by one with the shifted-out bit reported on carry_out.
module ula_xyz
    import caminho_dados_xyz_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  ula_op_t      op,
    output logic [W-1:0] resultado,
    output logic         carry_out
);

    logic [W:0] soma;
    logic [W:0] diferenca;

    // In W+1 bits the top bit of a-b is set exactly when a < b, i.e. the borrow.
    assign soma      = {1'b0, a} + {1'b0, b};
    assign diferenca = {1'b0, a} - {1'b0, b};

    always_comb begin
        resultado = a;
        carry_out = 1'b0;
        case (op)
            ULA_ADD: begin
                resultado = soma[W-1:0];
                carry_out = soma[W];
            end
            ULA_SUB: begin
                resultado = diferenca[W-1:0];
                carry_out = diferenca[W];
            end
            ULA_SHR: begin
                resultado = {1'b0, a[W-1:1]};
                carry_out = a[0];
            end
            default: begin
                resultado = a;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/caminho_dados_xyz.sv
// Datapath stage behind the program memory: executes one control word per
// enabled cycle on registers X, Y, Z and reports flags and one-cycle pulses.
module caminho_dados_xyz
    import caminho_dados_xyz_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         habilita,
    input  logic [3:0]   controle,
    input  logic [W-1:0] valor,
    output logic [W-1:0] reg_x,
    output logic [W-1:0] reg_y,
    output logic [W-1:0] reg_z,
    output logic         carry,
    output logic         zero,
    output logic         pronto,
    output logic         op_invalida
);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] z_q, z_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         pronto_q, pronto_d;
    logic         op_invalida_q, op_invalida_d;

    logic [W-1:0] ula_a;
    logic [W-1:0] ula_resultado;
    logic         ula_carry;
    ula_op_t      ula_op;

    // Shift works on Y alone; add and subtract are always X op Y.
    always_comb begin
        ula_a  = x_q;
        ula_op = ULA_SHR;
        case (controle)
            OP_ADD: begin
                ula_a  = x_q;
                ula_op = ULA_ADD;
            end
            OP_SUB: begin
                ula_a  = x_q;
                ula_op = ULA_SUB;
            end
            default: begin
                ula_a  = y_q;
                ula_op = ULA_SHR;
            end
        endcase
    end

    ula_xyz #(
        .W(W)
    ) u_ula (
        .a        (ula_a),
        .b        (y_q),
        .op       (ula_op),
        .resultado(ula_resultado),
        .carry_out(ula_carry)
    );

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        pronto_d      = 1'b0;
        op_invalida_d = 1'b0;
        if (habilita) begin
            case (controle)
                OP_LOAD_X: begin
                    x_d     = valor;
                    y_d     = '0;
                    z_d     = '0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                end
                OP_LOAD_Y: begin
                    y_d = valor;
                end
                OP_ADD, OP_SHR_Y, OP_SUB: begin
                    y_d     = ula_resultado;
                    carry_d = ula_carry;
                    zero_d  = (ula_resultado == '0);
                end
                OP_STORE_Z: begin
                    z_d      = y_q;
                    x_d      = '0;
                    y_d      = '0;
                    pronto_d = 1'b1;
                end
                default: begin
                    op_invalida_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            pronto_q      <= 1'b0;
            op_invalida_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            pronto_q      <= pronto_d;
            op_invalida_q <= op_invalida_d;
        end
    end

    assign reg_x       = x_q;
    assign reg_y       = y_q;
    assign reg_z       = z_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign pronto      = pronto_q;
    assign op_invalida = op_invalida_q;

endmodule
